// File: rtl/uart_io_pkg.sv
// Shared types and field positions for the CPU-side UART transmitter.
// Holds the init/TX state encodings, mode/command bit positions and baud decode.
package uart_io_pkg;

   typedef enum logic [1:0] {
      INIT_MODE = 2'd0,
      INIT_CMD  = 2'd1,
      INIT_RUN  = 2'd2
   } init_state_t;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_t;

   // mode word
   localparam int MODE_BAUD_LSB = 0;
   localparam int MODE_LEN_LSB  = 2;
   localparam int MODE_PEN      = 4;
   localparam int MODE_EVEN     = 5;
   localparam int MODE_STOP2    = 7;

   // command word
   localparam int CMD_TXEN  = 0;
   localparam int CMD_BREAK = 3;
   localparam int CMD_ERST  = 4;
   localparam int CMD_IRST  = 7;

   function automatic logic [6:0] baud_factor(
      input logic [1:0] sel
   );
      logic [6:0] f;
      unique case (sel)
         2'b10:   f = 7'd16;
         2'b11:   f = 7'd64;
         default: f = 7'd1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/uart_io_fifo.sv
// Synchronous TX byte FIFO with full/empty/count and same-cycle push+pop.
// Ports: clk, rst (sync, active-high), push/wdata, pop/rdata (show-ahead), full, empty, count.
module uart_io_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_io_tx.sv
// CPU I/O-port UART transmitter: mode/command init sequence, TX FIFO, serializer.
// Ports: wb_clk_i/wb_rst_i, wr_stb+io_d/io_c+bus_i writes, bus_o status, txd, irq_txe.
module uart_io_tx
   import uart_io_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CLK_DIV    = 16
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       wr_stb,
   input  logic       io_d,
   input  logic       io_c,
   input  logic [7:0] bus_i,
   output logic [7:0] bus_o,
   output logic       txd,
   output logic       irq_txe
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BIT_W = $clog2(CLK_DIV * 64) + 1;

   init_state_t init_q;
   init_state_t init_d;
   tx_state_t   tx_q;
   tx_state_t   tx_d;

   logic             ctl_wr;
   logic             data_wr;
   logic             mode_we;
   logic             cmd_we;
   logic             soft_rst;
   logic             rst_all;
   logic             run;
   logic [7:0]       mode_q;
   logic [7:0]       cmd_q;
   logic             ovr_q;

   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] count;
   logic [7:0]       rdata;

   logic             txen;
   logic             brk;
   logic             par_en;
   logic             stop2;
   logic             start_ok;
   logic [BIT_W-1:0] bit_cyc;
   logic [BIT_W-1:0] bit_cnt;
   logic             bit_end;
   logic [2:0]       bit_idx;
   logic [2:0]       last_idx;
   logic             stop_idx;
   logic             stop_last;
   logic [7:0]       len_mask;
   logic [7:0]       shreg;
   logic             par_q;
   logic             txd_q;
   logic             txd_d;
   logic [31:0]      cnt_ext;
   logic [3:0]       cnt_sat;
   logic             unused_bits;

   // ---------------- init FSM ----------------

   always_ff @(posedge wb_clk_i) begin
      if (rst_all) begin
         init_q <= INIT_MODE;
      end else begin
         init_q <= init_d;
      end
   end

   always_comb begin
      init_d = init_q;
      unique case (init_q)
         INIT_MODE: if (ctl_wr) init_d = INIT_CMD;
         INIT_CMD:  if (ctl_wr) init_d = INIT_RUN;
         default:   init_d = init_q;
      endcase
   end

   // io_d wins when both selects are set
   always_comb begin
      ctl_wr   = wr_stb & io_c & ~io_d;
      data_wr  = wr_stb & io_d;
      run      = (init_q == INIT_RUN);
      mode_we  = ctl_wr & (init_q == INIT_MODE);
      soft_rst = ctl_wr & (init_q != INIT_MODE) & bus_i[CMD_IRST];
      cmd_we   = ctl_wr & (init_q != INIT_MODE) & ~bus_i[CMD_IRST];
   end

   // internal reset acts on the write edge, exactly like the pin
   assign rst_all = wb_rst_i | soft_rst;

   // ---------------- config / flags ----------------

   always_ff @(posedge wb_clk_i) begin
      if (rst_all) begin
         mode_q <= '0;
         cmd_q  <= '0;
         ovr_q  <= 1'b0;
      end else begin
         if (mode_we) begin
            mode_q <= bus_i;
         end
         if (cmd_we) begin
            cmd_q           <= bus_i;
            cmd_q[CMD_ERST] <= 1'b0;
         end
         if (data_wr & run & full) begin
            ovr_q <= 1'b1;
         end else if (cmd_we & bus_i[CMD_ERST]) begin
            ovr_q <= 1'b0;
         end
      end
   end

   assign push = data_wr & run & ~full;

   uart_io_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (wb_clk_i),
      .rst   (rst_all),
      .push  (push),
      .wdata (bus_i),
      .pop   (pop),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // ---------------- TX FSM ----------------

   always_comb begin
      txen     = cmd_q[CMD_TXEN];
      brk      = cmd_q[CMD_BREAK];
      par_en   = mode_q[MODE_PEN];
      stop2    = mode_q[MODE_STOP2];
      bit_cyc  = BIT_W'(CLK_DIV *
                 int'(baud_factor(mode_q[MODE_BAUD_LSB +: 2])));
      last_idx = 3'd4 + {1'b0, mode_q[MODE_LEN_LSB +: 2]};
      len_mask = 8'hFF >> (2'd3 - mode_q[MODE_LEN_LSB +: 2]);
      bit_end  = (bit_cnt == bit_cyc - BIT_W'(1));
      stop_last = bit_end & (stop_idx == stop2);
      start_ok = txen & ~empty;
   end

   always_ff @(posedge wb_clk_i) begin
      if (rst_all) begin
         tx_q <= TX_IDLE;
      end else begin
         tx_q <= tx_d;
      end
   end

   always_comb begin
      tx_d = tx_q;
      unique case (tx_q)
         TX_IDLE: begin
            if (start_ok) tx_d = TX_START;
         end
         TX_START: begin
            if (bit_end) tx_d = TX_DATA;
         end
         TX_DATA: begin
            if (bit_end && bit_idx == last_idx) begin
               tx_d = par_en ? TX_PARITY : TX_STOP;
            end
         end
         TX_PARITY: begin
            if (bit_end) tx_d = TX_STOP;
         end
         TX_STOP: begin
            // chain straight into the next frame when data is waiting
            if (stop_last) begin
               tx_d = start_ok ? TX_START : TX_IDLE;
            end
         end
         default: tx_d = TX_IDLE;
      endcase
   end

   always_comb begin
      pop   = 1'b0;
      txd_d = 1'b1;
      unique case (tx_q)
         TX_IDLE:   pop = start_ok;
         TX_START:  txd_d = 1'b0;
         TX_DATA:   txd_d = shreg[bit_idx];
         TX_PARITY: txd_d = par_q;
         TX_STOP:   pop = start_ok & stop_last;
         default:   txd_d = 1'b1;
      endcase
      // break only masks the line; the bit timers keep running
      if (brk) begin
         txd_d = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (rst_all) begin
         bit_cnt  <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par_q    <= 1'b0;
         txd_q    <= 1'b1;
      end else begin
         txd_q <= txd_d;
         if (tx_q == TX_IDLE || bit_end) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (pop) begin
            shreg    <= rdata;
            par_q    <= ^(rdata & len_mask) ^ ~mode_q[MODE_EVEN];
            bit_idx  <= '0;
            stop_idx <= 1'b0;
         end else begin
            if (tx_q == TX_DATA && bit_end) begin
               bit_idx <= bit_idx + 1'b1;
            end
            if (tx_q == TX_STOP && bit_end) begin
               stop_idx <= ~stop_idx;
            end
         end
      end
   end

   assign txd = txd_q;

   // ---------------- status ----------------

   always_comb begin
      cnt_ext = 32'(count);
      cnt_sat = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
      bus_o   = {cnt_sat,
                 ovr_q,
                 empty & (tx_q == TX_IDLE),
                 run,
                 run & txen & ~full};
      irq_txe = txen & empty & (tx_q == TX_IDLE);
   end

   assign unused_bits = ^{mode_q[6], cmd_q[7:5], cmd_q[2:1],
                          cnt_ext[31:4]};

endmodule

// File: tb/tb_uart_io_tx.sv
// Scoreboarded bench for uart_io_tx: directed writes queue expected frames.
// A line monitor decodes txd frames and pops/compares; status is checked inline.
module tb_uart_io_tx;

   localparam int DEPTH = 8;
   localparam int DIV   = 4;

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i;
   logic       wr_stb;
   logic       io_d;
   logic       io_c;
   logic [7:0] bus_i;
   logic [7:0] bus_o;
   logic       txd;
   logic       irq_txe;

   always #5 wb_clk_i = ~wb_clk_i;

   uart_io_tx #(
      .FIFO_DEPTH (DEPTH),
      .CLK_DIV    (DIV)
   ) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .wr_stb   (wr_stb),
      .io_d     (io_d),
      .io_c     (io_c),
      .bus_i    (bus_i),
      .bus_o    (bus_o),
      .txd      (txd),
      .irq_txe  (irq_txe)
   );

   typedef struct {
      logic [15:0] bits;
      int          nbits;
      int          cyc;
      bit          contig;
   } frame_t;

   frame_t sb[$];
   int     checks = 0;
   int     errors = 0;
   bit     mon_en = 1'b1;
   bit     busy   = 1'b0;

   task automatic chk(input string name,
                      input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic ctl_wr(input logic [7:0] b);
      wr_stb = 1'b1; io_c = 1'b1; io_d = 1'b0; bus_i = b;
      @(negedge wb_clk_i);
      wr_stb = 1'b0; io_c = 1'b0;
   endtask

   task automatic dat_wr(input logic [7:0] b);
      wr_stb = 1'b1; io_d = 1'b1; io_c = 1'b0; bus_i = b;
      @(negedge wb_clk_i);
      wr_stb = 1'b0; io_d = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge wb_clk_i);
   endtask

   task automatic expect_frame(input logic [15:0] bits,
                               input int nb,
                               input int cyc,
                               input bit contig);
      frame_t f;
      f.bits = bits; f.nbits = nb; f.cyc = cyc; f.contig = contig;
      sb.push_back(f);
   endtask

   task automatic drain(input int max_cyc, input string name);
      int n;
      n = 0;
      while ((sb.size() != 0 || busy) && n < max_cyc) begin
         @(negedge wb_clk_i);
         n++;
      end
      checks++;
      if (sb.size() != 0 || busy) begin
         errors++;
         $display("FAIL %s drain: pending=%0d busy=%0d expected 0",
                  name, sb.size(), busy);
         sb.delete();
      end
   endtask

   // line monitor: frame decode and gap tracking
   initial begin
      frame_t      it;
      logic        prev;
      int          gap;
      logic [15:0] got;
      bit          stable;
      prev = 1'b1;
      gap  = 1000;
      forever begin
         @(negedge wb_clk_i);
         if (!mon_en) begin
            prev = txd;
            gap  = 1000;
         end else if (prev === 1'b1 && txd === 1'b0) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: start bit with empty queue");
               prev = txd;
            end else begin
               it   = sb.pop_front();
               busy = 1'b1;
               if (it.contig) begin
                  checks++;
                  if (gap != 0) begin
                     errors++;
                     $display("FAIL frame_gap: got %0d idle cycles expected 0",
                              gap);
                  end
               end
               got    = '0;
               stable = 1'b1;
               for (int b = 0; b < it.nbits; b++) begin
                  for (int s = 0; s < it.cyc; s++) begin
                     if (!(b == 0 && s == 0)) @(negedge wb_clk_i);
                     if (txd !== it.bits[b]) stable = 1'b0;
                     if (s == it.cyc / 2) got[b] = txd;
                  end
               end
               checks++;
               if (!stable || got !== it.bits) begin
                  errors++;
                  $display("FAIL frame: got %h stable=%0d expected %h",
                           got, stable, it.bits);
               end
               prev = 1'b1;
               gap  = 0;
               busy = 1'b0;
            end
         end else begin
            if (txd === 1'b1) gap++;
            prev = txd;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      wb_rst_i = 1'b1;
      wr_stb   = 1'b0;
      io_d     = 1'b0;
      io_c     = 1'b0;
      bus_i    = '0;
      idle(3);
      wb_rst_i = 1'b0;

      chk("reset_bus_o", bus_o, 8'h04);
      chk("reset_txd", {7'b0, txd}, 8'h01);
      chk("reset_irq", {7'b0, irq_txe}, 8'h00);

      // data write before RUN is ignored
      ctl_wr(8'h4D);
      dat_wr(8'hAA);
      chk("preinit_status", bus_o, 8'h04);
      ctl_wr(8'h01);
      chk("run_status", bus_o, 8'h07);
      chk("run_irq", {7'b0, irq_txe}, 8'h01);

      // single 8N1 frame, x1, 4 clocks per bit
      expect_frame({1'b1, 8'h55, 1'b0}, 10, 4, 1'b0);
      dat_wr(8'h55);
      chk("push_status", bus_o, 8'h13);
      chk("lat0_txd", {7'b0, txd}, 8'h01);
      idle(1);
      chk("pop_status", bus_o, 8'h03);
      chk("lat1_txd", {7'b0, txd}, 8'h01);
      idle(1);
      chk("lat2_txd", {7'b0, txd}, 8'h00);
      drain(100, "single");
      chk("single_done", bus_o, 8'h07);
      chk("single_irq", {7'b0, irq_txe}, 8'h01);

      // back-to-back frames
      expect_frame({1'b1, 8'hA5, 1'b0}, 10, 4, 1'b0);
      expect_frame({1'b1, 8'h0F, 1'b0}, 10, 4, 1'b1);
      expect_frame({1'b1, 8'hF0, 1'b0}, 10, 4, 1'b1);
      dat_wr(8'hA5);
      dat_wr(8'h0F);
      dat_wr(8'hF0);
      chk("b2b_irq_busy", {7'b0, irq_txe}, 8'h00);
      drain(300, "b2b");
      chk("b2b_irq_done", {7'b0, irq_txe}, 8'h01);
      chk("b2b_status", bus_o, 8'h07);

      // 6 bits, even parity, 2 stop, x16 -> 64 clocks per bit
      ctl_wr(8'h80);
      chk("irst_status", bus_o, 8'h04);
      ctl_wr(8'hF6);
      ctl_wr(8'h01);
      expect_frame({2'b11, 1'b1, 6'b111011, 1'b0}, 10, 64, 1'b0);
      dat_wr(8'h3B);
      drain(900, "even_parity");

      // 7 bits, odd parity, 1 stop; bit 7 of data discarded
      ctl_wr(8'h80);
      ctl_wr(8'h19);
      ctl_wr(8'h01);
      expect_frame({1'b1, 1'b0, 7'b1000011, 1'b0}, 10, 4, 1'b0);
      dat_wr(8'hC3);
      drain(100, "odd_parity");

      // overrun with TXEN=0, then TXEN pause mid-stream
      ctl_wr(8'h80);
      ctl_wr(8'h4D);
      ctl_wr(8'h00);
      chk("txoff_status", bus_o, 8'h06);
      for (int i = 0; i < DEPTH + 1; i++) begin
         dat_wr(8'(8'h10 + i));
      end
      chk("overrun_status", bus_o, 8'h8A);
      chk("overrun_irq", {7'b0, irq_txe}, 8'h00);
      ctl_wr(8'h10);
      chk("err_reset_status", bus_o, 8'h82);
      for (int i = 0; i < DEPTH; i++) begin
         expect_frame({1'b1, 8'(8'h10 + i), 1'b0}, 10, 4,
                      (i == 1) || (i >= 3));
      end
      ctl_wr(8'h01);
      idle(58);
      ctl_wr(8'h00);
      idle(60);
      chk("paused_status", bus_o, 8'h62);
      chk("paused_txd", {7'b0, txd}, 8'h01);
      ctl_wr(8'h01);
      drain(500, "queued");
      chk("queued_done", bus_o, 8'h07);

      // break
      mon_en = 1'b0;
      ctl_wr(8'h08);
      idle(1);
      chk("break_txd", {7'b0, txd}, 8'h00);
      chk("break_status", bus_o, 8'h06);
      ctl_wr(8'h00);
      idle(1);
      chk("unbreak_txd", {7'b0, txd}, 8'h01);

      // internal reset in the middle of a character
      ctl_wr(8'h01);
      dat_wr(8'h00);
      idle(10);
      chk("mid_char_txd", {7'b0, txd}, 8'h00);
      ctl_wr(8'h80);
      chk("abort_txd", {7'b0, txd}, 8'h01);
      chk("abort_status", bus_o, 8'h04);
      chk("abort_irq", {7'b0, irq_txe}, 8'h00);
      ctl_wr(8'h4D);
      chk("mode_first", bus_o, 8'h04);
      ctl_wr(8'h01);
      chk("rerun_status", bus_o, 8'h07);
      idle(2);
      mon_en = 1'b1;
      idle(1);
      expect_frame({1'b1, 8'h81, 1'b0}, 10, 4, 1'b0);
      dat_wr(8'h81);
      drain(100, "after_abort");
      chk("final_status", bus_o, 8'h07);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_io_tx.md
UART_IO_TX -- requirements
Module: uart_io_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: TX FIFO entries; power of two, at least 2.
REQ-002 Parameter CLK_DIV, default 16: base clocks per bit at baud factor x1; at least 1.
REQ-003 wb_clk_i  in  1  sole clock; every flop rises on this edge.
REQ-004 wb_rst_i  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 wr_stb  in  1  one-cycle write strobe from the CPU I/O bus.
REQ-006 io_d  in  1  data-port select; qualified by wr_stb.
REQ-007 io_c  in  1  control-port select; qualified by wr_stb; io_d has priority when both are set.
REQ-008 bus_i  in  8  write data.
REQ-009 bus_o  out  8  status word; combinational from registered state.
REQ-010 txd  out  1  serial output; idle high.
REQ-011 irq_txe  out  1  high while TXEN=1, FIFO empty and shifter idle.

Function
REQ-012 Init FSM: INIT_MODE -> INIT_CMD -> RUN.
- In INIT_MODE, a control write (io_c) latches bus_i as the mode word.
- In INIT_CMD, a control write latches bus_i as the command word.
- In RUN, a control write updates the command word.
REQ-013 Mode word fields:
- [1:0] baud factor: 00/01=x1, 10=x16, 11=x64. BIT_CYC = CLK_DIV*factor.
- [3:2] character length: 00=5 ... 11=8 bits.
- [4] parity enable; [5] even parity.
- [7:6] stop bits: 00/01=1, 10/11=2.
REQ-014 Command word fields:
- [0] TXEN.
- [3] break: txd forced low while set.
- [4] error reset: clears overrun and is not stored.
- [7] internal reset.
REQ-015 Internal reset takes effect on the write edge and has the same effect as wb_rst_i; the next cycle is in INIT_MODE.
REQ-016 A data write (io_d) in RUN with the FIFO not full pushes bus_i on that edge.
REQ-017 A data write before RUN is ignored and does not set overrun.
REQ-018 A data write to a full FIFO is dropped and sets the sticky overrun flag.
REQ-019 A push and a pop in the same cycle both occur; the count is unchanged.
REQ-020 TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- In IDLE with TXEN=1 and the FIFO not empty, pop one byte in the current cycle; txd drives the start bit from the next cycle.
- Latency: the start bit appears 2 cycles after the write edge when the FIFO was empty.
REQ-021 Each bit is held exactly BIT_CYC cycles.
- Data bits are sent LSB first, character-length bits only; upper bits are discarded.
- Parity is the XOR of the sent bits, inverted for odd parity.
- Stop bits are high.
REQ-022 STOP returns directly to START, with no idle gap, when TXEN=1 and the FIFO is not empty.
REQ-023 Clearing TXEN mid-character completes the current character, then holds IDLE; queued bytes are retained.
REQ-024 Break overrides txd at any state and does not pause the bit counters.
REQ-025 Status bus_o:
- [0] TXRDY = RUN & TXEN & !full.
- [1] RUN.
- [2] TXEMPTY = FIFO empty & IDLE.
- [3] overrun.
- [7:4] FIFO count, saturated at 15.

Reset
REQ-026 On wb_rst_i:
- Init FSM to INIT_MODE; TX FSM to IDLE; FIFO flushed.
- Mode and command words to 0; overrun to 0; txd=1.
- bus_o reset value: 8'h04; irq_txe=0.
REQ-027 A reset mid-character aborts it; txd is 1 in the cycle after the reset edge.

Structure
REQ-028 Shared package uart_io_pkg holds:
- Init and TX state enums.
- Mode and command bit-position constants.
- Baud-factor decode function.
REQ-029 The FIFO is the sub-module uart_io_fifo (depth FIFO_DEPTH, width 8, synchronous, full/empty/count outputs, simultaneous push/pop); all other logic is in uart_io_tx.

Verification
REQ-030 Init and send: CLK_DIV=4; mode 8'h4D (x1, 8 bits, no parity, 1 stop); command 8'h01; data 8'h55 -> txd low 2 cycles after the write edge, then 1,0,1,0,1,0,1,0, then stop high; each bit 4 cycles; bus_o[2] returns to 1.
REQ-031 Parity and 2 stop bits: mode 8'hF6 (x16, 6 bits, even parity, 2 stop), CLK_DIV=1; data 8'h3B -> 6 data bits 1,1,0,1,1,1, parity 1, 2 stop bits, each 16 cycles.
REQ-032 Overrun: TXEN=0; push FIFO_DEPTH+1 bytes -> bus_o[0]=0, bus_o[3]=1, count=8; command 8'h10 -> bus_o[3]=0, count still 8.
REQ-033 Back-to-back: queue 3 bytes with TXEN=1 -> 3 contiguous frames with no idle gap; irq_txe rises after the last stop bit.
REQ-034 Reset mid-character: command 8'h80 during DATA -> txd=1 next cycle; bus_o=8'h04; the next control write is taken as the mode word.
REQ-035 Pre-init write: data write in INIT_CMD -> FIFO count 0, overrun 0.
